// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus single-outstanding instruction fetch from a
// variable-latency memory, with sticky misalignment / timeout fault reporting.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IMEM_AW  = 10,
   parameter int          TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        nextpc,
   input  logic               advance,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        pc,
   output logic [31:0]        instr,
   output logic               instr_valid,
   output logic               fault,
   output logic [1:0]         fault_code,
   output logic [31:0]        retired
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
   localparam logic [1:0] CODE_MISALIGN = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_nxt;
   logic [31:0] pc_offset;

   assign wait_nxt  = wait_cnt + 8'd1;
   assign pc_offset = pc - RESET_PC;
   assign imem_addr = IMEM_AW'(pc_offset >> 2);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         fault       <= 1'b0;
         fault_code  <= 2'b00;
         retired     <= 32'd0;
         wait_cnt    <= 8'd0;
      end else begin
         case (state)
            FETCH: begin
               // First cycle after reset has no request out yet, so any ack is stale.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  wait_cnt    <= 8'd0;
                  state       <= HOLD;
               end else if (wait_nxt == TIMEOUT_CNT) begin
                  wait_cnt   <= wait_nxt;
                  fault      <= 1'b1;
                  fault_code <= CODE_TIMEOUT;
                  imem_req   <= 1'b0;
                  state      <= FAULT;
               end else begin
                  wait_cnt <= wait_nxt;
               end
            end
            HOLD: begin
               if (advance) begin
                  instr_valid <= 1'b0;
                  if (nextpc[1:0] == 2'b00) begin
                     pc       <= nextpc;
                     retired  <= retired + 32'd1;
                     imem_req <= 1'b1;
                     wait_cnt <= 8'd0;
                     state    <= FETCH;
                  end else begin
                     fault      <= 1'b1;
                     fault_code <= CODE_MISALIGN;
                     state      <= FAULT;
                  end
               end
            end
            default: begin
               instr_valid <= 1'b0;
               imem_req    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change and outputs are sampled on
// the falling edge, halfway between active edges.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] nextpc;
   logic        advance;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fault;
   logic [1:0]  fault_code;
   logic [31:0] retired;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(.RESET_PC(32'h0000_3000), .IMEM_AW(10), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .nextpc(nextpc), .advance(advance),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .instr_valid(instr_valid),
      .fault(fault), .fault_code(fault_code), .retired(retired)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; advance = 1'b0; nextpc = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
      step();
      checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0000_3000); end
      checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr); end
      checks++; if ({instr_valid, imem_req, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {instr_valid, imem_req, fault}); end
      checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL reset_code got=%b exp=00", fault_code); end
      checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired); end
      reset = 1'b0;
   endtask

   task automatic test_first_fetch();
      step();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ff_req got=%b exp=1", imem_req); end
      checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL ff_addr got=%0d exp=0", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
      step();
      imem_ack = 1'b0;
      checks++; if (instr !== 32'h2008_0005) begin errors++; $display("FAIL ff_instr got=%h exp=%h", instr, 32'h2008_0005); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ff_valid got=%b exp=1", instr_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ff_req_drop got=%b exp=0", imem_req); end
      checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL ff_pc got=%h exp=%h", pc, 32'h0000_3000); end
      // ack while holding must be ignored
      imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
      step();
      imem_ack = 1'b0;
      checks++; if (instr !== 32'h2008_0005 || instr_valid !== 1'b1) begin errors++; $display("FAIL hold_ack got=%h/%b exp=%h/1", instr, instr_valid, 32'h2008_0005); end
   endtask

   task automatic test_advance();
      advance = 1'b1; nextpc = 32'h0000_3004;
      step();
      advance = 1'b0;
      checks++; if (pc !== 32'h0000_3004) begin errors++; $display("FAIL adv_pc got=%h exp=%h", pc, 32'h0000_3004); end
      checks++; if (imem_addr !== 10'd1) begin errors++; $display("FAIL adv_addr got=%0d exp=1", imem_addr); end
      checks++; if (retired !== 32'd1) begin errors++; $display("FAIL adv_retired got=%0d exp=1", retired); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL adv_valid got=%b exp=0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL adv_req got=%b exp=1", imem_req); end
   endtask

   task automatic test_delayed_ack();
      advance = 1'b1; nextpc = 32'h0000_3100;
      step();
      advance = 1'b0;
      checks++; if (pc !== 32'h0000_3004 || retired !== 32'd1) begin errors++; $display("FAIL dly_pc got=%h/%0d exp=%h/1", pc, retired, 32'h0000_3004); end
      checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL dly_wait got=%b%b exp=10", imem_req, instr_valid); end
      step();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      checks++; if (instr !== 32'hDEAD_BEEF || instr_valid !== 1'b1) begin errors++; $display("FAIL dly_capture got=%h/%b exp=%h/1", instr, instr_valid, 32'hDEAD_BEEF); end
      checks++; if (pc !== 32'h0000_3004) begin errors++; $display("FAIL dly_pc_after got=%h exp=%h", pc, 32'h0000_3004); end
   endtask

   task automatic test_self_loop();
      advance = 1'b1; nextpc = 32'h0000_3004;
      step();
      advance = 1'b0;
      checks++; if (retired !== 32'd2 || imem_addr !== 10'd1 || imem_req !== 1'b1) begin errors++; $display("FAIL loop_refetch got=%0d/%0d/%b exp=2/1/1", retired, imem_addr, imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'hABCD_0123;
      step();
      imem_ack = 1'b0;
      checks++; if (instr !== 32'hABCD_0123 || instr_valid !== 1'b1) begin errors++; $display("FAIL loop_capture got=%h/%b exp=%h/1", instr, instr_valid, 32'hABCD_0123); end
   endtask

   task automatic test_timeout();
      advance = 1'b1; nextpc = 32'h0000_3008;
      step();
      advance = 1'b0;
      for (int i = 0; i < 15; i++) step();
      checks++; if (fault !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL to_early got=%b%b exp=01", fault, imem_req); end
      step();
      checks++; if (fault !== 1'b1 || fault_code !== 2'b10) begin errors++; $display("FAIL to_fault got=%b/%b exp=1/10", fault, fault_code); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL to_req got=%b exp=0", imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678; advance = 1'b1; nextpc = 32'h0000_3010;
      for (int i = 0; i < 4; i++) step();
      imem_ack = 1'b0; advance = 1'b0;
      checks++; if (pc !== 32'h0000_3008 || retired !== 32'd3) begin errors++; $display("FAIL to_frozen_pc got=%h/%0d exp=%h/3", pc, retired, 32'h0000_3008); end
      checks++; if (instr !== 32'hABCD_0123 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL to_frozen_out got=%h/%b%b exp=%h/00", instr, instr_valid, imem_req, 32'hABCD_0123); end
      checks++; if (fault !== 1'b1 || fault_code !== 2'b10) begin errors++; $display("FAIL to_sticky got=%b/%b exp=1/10", fault, fault_code); end
   endtask

   task automatic test_misaligned();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
      step();
      imem_ack = 1'b0;
      advance = 1'b1; nextpc = 32'h0000_3006;
      step();
      advance = 1'b0;
      checks++; if (fault !== 1'b1 || fault_code !== 2'b01) begin errors++; $display("FAIL mis_fault got=%b/%b exp=1/01", fault, fault_code); end
      checks++; if (pc !== 32'h0000_3000 || retired !== 32'd0) begin errors++; $display("FAIL mis_pc got=%h/%0d exp=%h/0", pc, retired, 32'h0000_3000); end
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mis_out got=%b%b exp=00", instr_valid, imem_req); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (pc !== 32'h0000_3000 || fault !== 1'b0 || fault_code !== 2'b00) begin errors++; $display("FAIL mis_reset got=%h/%b/%b exp=%h/0/00", pc, fault, fault_code, 32'h0000_3000); end
   endtask

   task automatic test_reset_mid_fetch();
      step();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmf_req_pre got=%b exp=1", imem_req); end
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      step();
      reset = 1'b0;
      checks++; if (instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rmf_in_reset got=%h/%b%b exp=0/00", instr, instr_valid, imem_req); end
      step();
      imem_ack = 1'b0;
      checks++; if (instr !== 32'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rmf_late_ack got=%h/%b exp=0/0", instr, instr_valid); end
      checks++; if (imem_req !== 1'b1 || retired !== 32'd0) begin errors++; $display("FAIL rmf_restart got=%b/%0d exp=1/0", imem_req, retired); end
      imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
      step();
      imem_ack = 1'b0;
      checks++; if (instr !== 32'h2222_2222 || instr_valid !== 1'b1) begin errors++; $display("FAIL rmf_refetch got=%h/%b exp=%h/1", instr, instr_valid, 32'h2222_2222); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_first_fetch();
      test_advance();
      test_delayed_ack();
      test_self_loop();
      test_timeout();
      test_misaligned();
      test_reset_mid_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the architectural PC register and fetches one instruction per PC from a variable-latency instruction memory.
- Sits directly downstream of the next-PC logic:
  - consumes its 32-bit next-address result;
  - presents {pc, instr} to decode/control.
- Sequences fetch → hold → advance with a req/ack handshake.
- Faults on a misaligned target or a memory timeout.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; also the base subtracted to form the memory word index.
- IMEM_AW, 10, width of the instruction-memory word index.
- TIMEOUT, 16, maximum cycles to wait for imem_ack before faulting (must be 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- nextpc  input  32  next-PC value from the next-PC logic; sampled only on an advance.
- advance  input  1  core has finished the held instruction; load nextpc.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  IMEM_AW  word index = (pc - RESET_PC) >> 2, truncated to IMEM_AW bits.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- pc  output  32  current PC.
- instr  output  32  captured instruction.
- instr_valid  output  1  instr corresponds to pc and may be executed.
- fault  output  1  sticky fault flag.
- fault_code  output  2  00 none, 01 misaligned nextpc, 10 fetch timeout.
- retired  output  32  count of accepted advances.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Values on the reset edge: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0, fault_code=00, retired=0, wait counter=0.
  - State goes to FETCH.
  - Reset asserted mid-fetch abandons the request; a late imem_ack is ignored while reset=1 and in the following cycle (state FETCH restarts cleanly with imem_req asserted).
- States: FETCH, HOLD, FAULT.
- FETCH:
  - imem_req=1; imem_addr driven from pc, stable until ack.
  - Wait counter increments each cycle without ack.
  - imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, counter<=0, go HOLD.
  - Ack may arrive on the first cycle imem_req is high, giving 1-cycle minimum latency.
  - Counter reaches TIMEOUT with no ack: fault<=1, fault_code<=10, imem_req<=0, go FAULT.
  - advance is ignored in FETCH.
- HOLD:
  - instr_valid=1; pc and instr stable; imem_req=0.
  - imem_ack while not requesting is ignored.
  - advance=1 and nextpc[1:0]==00: pc<=nextpc, retired<=retired+1, instr_valid<=0, go FETCH. Latency from advance to new imem_req is 1 cycle.
  - advance=1 and nextpc[1:0]!=00: pc unchanged, retired unchanged, instr_valid<=0, fault<=1, fault_code<=01, go FAULT.
- FAULT:
  - Terminal until reset; all outputs frozen except instr_valid=0 and imem_req=0.
- Arithmetic and wrap rules:
  - retired wraps 32'hFFFF_FFFF→0.
  - imem_addr subtraction is modulo 2^32, then shifted right by 2 and truncated; a pc below RESET_PC wraps silently.
- nextpc equal to pc (a self-loop) is legal: re-fetch the same word and increment retired.

Test Plan:
- Reset then ack after 1 cycle with imem_rdata=32'h2008_0005 → imem_addr=0, pc=32'h0000_3000, instr=32'h2008_0005, instr_valid=1 on the cycle after ack.
- In HOLD, advance with nextpc=32'h0000_3004 → pc=32'h0000_3004, imem_addr=1, retired=1, instr_valid=0 for at least one cycle, imem_req=1 next cycle.
- Memory delays ack 3 cycles, advance pulsed during the wait → advance ignored, pc unchanged, capture occurs on the ack cycle.
- No ack for TIMEOUT=16 cycles → fault=1, fault_code=10, imem_req=0; later ack and advance ignored until reset.
- HOLD, advance with nextpc=32'h0000_3006 → fault_code=01, pc stays at old value, retired unchanged; after reset, pc=32'h0000_3000 and fault=0.
- Reset asserted in FETCH coincident with imem_ack → instr stays 0, fresh request issued after reset drops, retired=0.
